// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: LC-3 register file with write bypass, busy scoreboard and NZP codes.
module regfile_scoreboard #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] dr_sel,
  input  logic [WIDTH-1:0]  dr_in,
  input  logic              load_reg,
  input  logic              load_cc,
  input  logic [ADDR_W-1:0] sr1_sel,
  input  logic [ADDR_W-1:0] sr2_sel,
  output logic [WIDTH-1:0]  sr1_out,
  output logic [WIDTH-1:0]  sr2_out,
  output logic              sr1_busy,
  output logic              sr2_busy,
  input  logic              rsv_en,
  input  logic [ADDR_W-1:0] rsv_sel,
  output logic              rsv_ok,
  output logic [2:0]        nzp
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busy;
  logic wr1, wr2, wr_rsv;
  always_comb begin
    wr1      = load_reg && dr_sel == sr1_sel;
    wr2      = load_reg && dr_sel == sr2_sel;
    wr_rsv   = load_reg && dr_sel == rsv_sel;
    sr1_out  = rst ? '0 : wr1 ? dr_in : regs[sr1_sel];
    sr2_out  = rst ? '0 : wr2 ? dr_in : regs[sr2_sel];
    sr1_busy = !rst && busy[sr1_sel] && !wr1;
    sr2_busy = !rst && busy[sr2_sel] && !wr2;
    rsv_ok   = !rst && rsv_en && (!busy[rsv_sel] || wr_rsv);
  end
  // Reservation is applied after the write's clear so a same-index reserve wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      busy <= '0;
      nzp  <= 3'b010;
    end else begin
      if (load_reg) begin
        regs[dr_sel] <= dr_in;
        busy[dr_sel] <= 1'b0;
      end
      if (rsv_ok) busy[rsv_sel] <= 1'b1;
      if (load_cc) nzp <= {dr_in[WIDTH-1], dr_in == '0, !dr_in[WIDTH-1] && |dr_in};
    end
  end
endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and randomized checks against an array-based reference model.
module tb_regfile_scoreboard;
  logic clk = 0, rst = 0, load_reg = 0, load_cc = 0, rsv_en = 0;
  logic [2:0] dr_sel = 0, sr1_sel = 0, sr2_sel = 0, rsv_sel = 0;
  logic [15:0] dr_in = 0;
  logic [15:0] sr1_out, sr2_out;
  logic sr1_busy, sr2_busy, rsv_ok;
  logic [2:0] nzp;
  int errors = 0, checks = 0;
  logic [15:0] m_reg [8];
  logic m_busy [8];
  logic [2:0] m_nzp;

  regfile_scoreboard #(.WIDTH(16), .ADDR_W(3)) dut (
    .clk(clk), .rst(rst), .dr_sel(dr_sel), .dr_in(dr_in), .load_reg(load_reg),
    .load_cc(load_cc), .sr1_sel(sr1_sel), .sr2_sel(sr2_sel), .sr1_out(sr1_out),
    .sr2_out(sr2_out), .sr1_busy(sr1_busy), .sr2_busy(sr2_busy), .rsv_en(rsv_en),
    .rsv_sel(rsv_sel), .rsv_ok(rsv_ok), .nzp(nzp)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] e_out(logic [2:0] s);
    if (rst) return 16'h0;
    return (load_reg && dr_sel == s) ? dr_in : m_reg[s];
  endfunction
  function automatic logic e_busy(logic [2:0] s);
    return !rst && m_busy[s] && !(load_reg && dr_sel == s);
  endfunction
  function automatic logic e_ok();
    return !rst && rsv_en && (!m_busy[rsv_sel] || (load_reg && dr_sel == rsv_sel));
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      m_reg[i] = 0;
      m_busy[i] = 0;
    end
    m_nzp = 3'b010;
  endtask

  task automatic model_edge();
    logic ok;
    if (rst) return;
    ok = e_ok();
    if (load_reg) begin
      m_reg[dr_sel] = dr_in;
      m_busy[dr_sel] = 0;
    end
    if (ok) m_busy[rsv_sel] = 1;
    if (load_cc) m_nzp = dr_in[15] ? 3'b100 : (dr_in == 0) ? 3'b010 : 3'b001;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic idle();
    load_reg = 0; load_cc = 0; rsv_en = 0;
  endtask

  task automatic test_reset();
    rst = 1;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    idle();
    for (int i = 0; i < 8; i++) begin
      sr1_sel = i[2:0]; sr2_sel = 3'(7 - i);
      #1;
      checks++;
      if (sr1_out !== 16'h0 || sr2_out !== 16'h0 || sr1_busy !== 1'b0 || sr2_busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_read idx=%0d got %h/%h busy %b/%b want 0000/0000 busy 0/0", i, sr1_out, sr2_out, sr1_busy, sr2_busy);
      end
    end
    checks++;
    if (nzp !== 3'b010) begin errors++; $display("FAIL reset_nzp got %b want 010", nzp); end
  endtask

  task automatic test_write_bypass();
    dr_sel = 3; dr_in = 16'hBEEF; load_reg = 1; sr1_sel = 3;
    #1;
    checks++;
    if (sr1_out !== 16'hBEEF) begin errors++; $display("FAIL bypass got %h want beef", sr1_out); end
    tick();
    load_reg = 0; sr1_sel = 3; sr2_sel = 3;
    #1;
    checks++;
    if (sr1_out !== 16'hBEEF || sr2_out !== 16'hBEEF) begin
      errors++; $display("FAIL write_read got %h/%h want beef/beef", sr1_out, sr2_out);
    end
    sr1_sel = 4;
    #1;
    checks++;
    if (sr1_out !== 16'h0) begin errors++; $display("FAIL r4_untouched got %h want 0000", sr1_out); end
  endtask

  task automatic test_scoreboard();
    rsv_en = 1; rsv_sel = 5; sr2_sel = 5;
    #1;
    checks++;
    if (rsv_ok !== 1'b1) begin errors++; $display("FAIL rsv_accept got %b want 1", rsv_ok); end
    tick();
    #1;
    checks++;
    if (sr2_busy !== 1'b1) begin errors++; $display("FAIL busy_after_rsv got %b want 1", sr2_busy); end
    checks++;
    if (rsv_ok !== 1'b0) begin errors++; $display("FAIL rsv_refuse got %b want 0", rsv_ok); end
    tick();
    rsv_en = 0; load_reg = 1; dr_sel = 5; dr_in = 16'h0007;
    #1;
    checks++;
    if (sr2_busy !== 1'b0 || sr2_out !== 16'h0007) begin
      errors++; $display("FAIL write_clears_hazard got busy=%b out=%h want 0/0007", sr2_busy, sr2_out);
    end
    tick();
    load_reg = 0;
    #1;
    checks++;
    if (sr2_busy !== 1'b0 || sr2_out !== 16'h0007) begin
      errors++; $display("FAIL busy_cleared got busy=%b out=%h want 0/0007", sr2_busy, sr2_out);
    end
  endtask

  task automatic test_write_reserve();
    rsv_en = 1; rsv_sel = 2;
    tick();
    load_reg = 1; dr_sel = 2; dr_in = 16'h5A5A;
    #1;
    checks++;
    if (rsv_ok !== 1'b1) begin errors++; $display("FAIL wr_rsv_ok got %b want 1", rsv_ok); end
    tick();
    idle(); sr1_sel = 2;
    #1;
    checks++;
    if (sr1_out !== 16'h5A5A || sr1_busy !== 1'b1) begin
      errors++; $display("FAIL wr_rsv_state got %h busy=%b want 5a5a busy=1", sr1_out, sr1_busy);
    end
  endtask

  task automatic test_nzp();
    logic [15:0] v [3] = '{16'h8000, 16'h0000, 16'h0001};
    logic [2:0] e [3] = '{3'b100, 3'b010, 3'b001};
    for (int i = 0; i < 3; i++) begin
      load_cc = 1; load_reg = 0; dr_sel = 3; dr_in = v[i];
      tick();
      load_cc = 0;
      #1;
      checks++;
      if (nzp !== e[i]) begin errors++; $display("FAIL nzp dr_in=%h got %b want %b", v[i], nzp, e[i]); end
    end
    sr1_sel = 3;
    #1;
    checks++;
    if (sr1_out !== 16'hBEEF) begin errors++; $display("FAIL cc_only_no_write got %h want beef", sr1_out); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 300; n++) begin
      dr_sel = 3'($urandom); sr1_sel = 3'($urandom); sr2_sel = 3'($urandom); rsv_sel = 3'($urandom);
      dr_in = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
      load_reg = ($urandom_range(0, 2) == 0); load_cc = $urandom_range(0, 1) == 1;
      rsv_en = ($urandom_range(0, 1) == 1);
      #1;
      checks++;
      if (sr1_out !== e_out(sr1_sel) || sr2_out !== e_out(sr2_sel) || sr1_busy !== e_busy(sr1_sel) ||
          sr2_busy !== e_busy(sr2_sel) || rsv_ok !== e_ok() || nzp !== m_nzp) begin
        errors++;
        $display("FAIL random n=%0d got %h %h %b %b %b %b want %h %h %b %b %b %b", n, sr1_out, sr2_out,
                 sr1_busy, sr2_busy, rsv_ok, nzp, e_out(sr1_sel), e_out(sr2_sel), e_busy(sr1_sel),
                 e_busy(sr2_sel), e_ok(), m_nzp);
      end
      tick();
    end
    idle();
  endtask

  task automatic test_async_reset();
    load_reg = 1; dr_sel = 1; dr_in = 16'h1234; rsv_en = 1; rsv_sel = 1;
    tick();
    load_reg = 1; dr_sel = 6; dr_in = 16'h8000; load_cc = 1; rsv_en = 0;
    tick();
    idle(); sr1_sel = 1; sr2_sel = 1;
    #1;
    checks++;
    if (sr1_out !== 16'h1234 || sr1_busy !== 1'b1 || nzp !== 3'b100) begin
      errors++; $display("FAIL pre_reset got %h busy=%b nzp=%b want 1234 1 100", sr1_out, sr1_busy, nzp);
    end
    #1 rst = 1;
    model_reset();
    load_reg = 1; dr_sel = 1; dr_in = 16'hFFFF; rsv_en = 1; rsv_sel = 3; load_cc = 1;
    #1;
    checks++;
    if (sr1_out !== 16'h0 || sr2_busy !== 1'b0 || nzp !== 3'b010 || rsv_ok !== 1'b0) begin
      errors++; $display("FAIL async_reset got %h busy=%b nzp=%b ok=%b want 0000 0 010 0", sr1_out, sr2_busy, nzp, rsv_ok);
    end
    tick();
    rst = 0; idle();
    #1;
    checks++;
    if (sr1_out !== 16'h0 || sr1_busy !== 1'b0 || nzp !== 3'b010) begin
      errors++; $display("FAIL write_during_reset got %h busy=%b nzp=%b want 0000 0 010", sr1_out, sr1_busy, nzp);
    end
    load_reg = 1; dr_sel = 1; dr_in = 16'h00AA;
    tick();
    idle();
    #1;
    checks++;
    if (sr1_out !== 16'h00AA) begin errors++; $display("FAIL first_write_after_reset got %h want 00aa", sr1_out); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_write_bypass();
    test_scoreboard();
    test_write_reserve();
    test_nzp();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/regfile_scoreboard.md
# regfile_scoreboard

Parametrised general-purpose register file for the LC-3 datapath with a write-to-read bypass, per-register busy scoreboard and an NZP condition-code register. It sits between decode and the ALU/memory stages: decode reads sources and reserves the destination, and writeback writes the result, clears the reservation and optionally updates NZP. It supports pipelined issue where the previous file assumed a single-cycle datapath.

## Interface
- WIDTH, 16, register data width in bits (≥2)
- ADDR_W, 3, register index width; DEPTH = 2**ADDR_W registers

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- dr_sel  in  ADDR_W  writeback destination index
- dr_in  in  WIDTH  writeback data
- load_reg  in  1  write dr_in into register dr_sel at the clock edge
- load_cc  in  1  update nzp from dr_in at the clock edge (independent of load_reg)
- sr1_sel, sr2_sel  in  ADDR_W  source read indices
- sr1_out, sr2_out  out  WIDTH  source read data (combinational)
- sr1_busy, sr2_busy  out  1  source has an outstanding reservation (combinational)
- rsv_en  in  1  request reservation of register rsv_sel
- rsv_sel  in  ADDR_W  register to reserve
- rsv_ok  out  1  reservation request accepted this cycle (combinational)
- nzp  out  3  condition codes {N,Z,P}, registered

## Operation
- State: array reg[0..DEPTH-1] of WIDTH bits; busy[0..DEPTH-1]; nzp.
- Reset (async, immediate): all registers 0, all busy 0, nzp = 3'b010. While rst is high, sr1_out/sr2_out = 0, srX_busy = 0, rsv_ok = 0, and no writes occur.
- Write: at posedge, if load_reg, reg[dr_sel] <= dr_in and busy[dr_sel] <= 0 (unless re-reserved, see below).
- Read with bypass: srX_out = dr_in when load_reg && dr_sel == srX_sel; otherwise reg[srX_sel]. Both ports are independent and may select the same index.
- Busy report: srX_busy = busy[srX_sel] && !(load_reg && dr_sel == srX_sel). A write in flight resolves the hazard through the bypass.
- Reservation: rsv_ok = rsv_en && (!busy[rsv_sel] || (load_reg && dr_sel == rsv_sel)). If rsv_ok, busy[rsv_sel] <= 1 at the edge. A refused request (rsv_ok = 0) changes nothing, and the requester must retry.
- Simultaneous write and reservation of the same index: the data is written and busy ends at 1 (reserve wins).
- Write to a non-busy register is legal; busy stays 0.
- Condition codes: at posedge, if load_cc, nzp <= {dr_in[WIDTH-1], dr_in == 0, !dr_in[WIDTH-1] && dr_in != 0}. Exactly one bit is ever set.
- Index arithmetic is unsigned, ADDR_W bits. All indices are valid, so there is no out-of-range case.

## Timing
- Reads, busy and rsv_ok are zero-latency combinational from inputs and state.
- Writes, busy updates and nzp become visible one cycle after the enabling edge. Bypass makes write data visible on read ports in the same cycle as load_reg.
- Reserve-to-busy latency: busy reads 1 on the cycle after the accepting edge.
- Reset asserted mid-operation discards any pending write, reservation or cc update in that cycle. Deassertion is synchronous to the design only through the next clk edge; the first write is accepted on the first posedge after rst falls.

## Test plan
- Reset: assert rst, release; read all 8 indices on both ports -> all 0x0000, srX_busy = 0, nzp = 3'b010.
- Write/read/bypass: write R3 = 0xBEEF with sr1_sel = 3 in the same cycle -> sr1_out = 0xBEEF that cycle; next cycle, with load_reg = 0, sr1_out and sr2_out (sel 3) = 0xBEEF and R4 still reads 0.
- Scoreboard: reserve R5 -> rsv_ok = 1, next cycle sr2_busy(sel 5) = 1. Re-reserve R5 -> rsv_ok = 0. Write R5 = 0x0007 -> sr2_busy = 0 in the same cycle and busy cleared after the edge.
- Same-cycle write and reserve of R2 with R2 busy -> rsv_ok = 1, R2 = new data, busy[2] = 1 afterwards.
- NZP: load_cc with dr_in = 0x8000 -> 3'b100; 0x0000 -> 3'b010; 0x0001 -> 3'b001. load_reg = 0 with load_cc = 1 leaves all registers unchanged.
- Async reset mid-run: R1 = 0x1234, busy[1] = 1, assert rst between edges -> outputs read 0, busy 0, nzp = 3'b010 immediately without a clock edge.
